// File: rtl/switch_ctrl_pkg.sv
// switch_ctrl_pkg: shared state encodings and sizing helper for the switch event controller
package switch_ctrl_pkg;
  typedef enum logic [1:0] {WAIT_PRESS, WAIT_RELEASE, PULSE} btn_state_t;
  typedef enum logic {ARB_IDLE, ARB_PRESENT} arb_state_t;
  function automatic int id_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: one button's 2-flop synchroniser, debounce counter and press/release FSM
module btn_debounce
  import switch_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic clck_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic release_pulse
);
  localparam int CW = $clog2(DEBOUNCE_CYC);
  logic r_s1, r_s2, r_deb, r_pulse, w_pulse;
  logic [CW-1:0] r_cnt;
  btn_state_t r_state, w_next;
  // synchronise the raw level and accept a new level only after it has been stable long enough
  always_ff @(posedge clck_i or posedge rst_i) begin
    if (rst_i) begin
      r_s1  <= 1'b0;
      r_s2  <= 1'b0;
      r_deb <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_s1 <= btn_i;
      r_s2 <= r_s1;
      if (r_s2 == r_deb) r_cnt <= '0;
      else if (r_cnt == CW'(DEBOUNCE_CYC - 1)) begin
        r_deb <= r_s2;
        r_cnt <= '0;
      end else r_cnt <= r_cnt + 1'b1;
    end
  end
  // button FSM state register plus registered release pulse
  always_ff @(posedge clck_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= WAIT_PRESS;
      r_pulse <= 1'b0;
    end else begin
      r_state <= w_next;
      r_pulse <= w_pulse;
    end
  end
  // next state: a press must be seen before its release counts as an event
  always_comb begin
    w_next = (r_state == WAIT_PRESS)   ? (r_deb ? WAIT_RELEASE : WAIT_PRESS) :
             (r_state == WAIT_RELEASE) ? (r_deb ? WAIT_RELEASE : PULSE) : WAIT_PRESS;
  end
  // output decode: one cycle of PULSE yields one event
  always_comb begin
    w_pulse = (r_state == PULSE);
  end
  assign release_pulse = r_pulse;
endmodule

// File: rtl/switch_event_ctrl.sv
// switch_event_ctrl: debounced button events latched as pending flags and presented round-robin via valid/ack
// Optional: define SWITCH_IRQ_EN to add registered irq_o = ev_valid_o | overrun_o.
module switch_event_ctrl
  import switch_ctrl_pkg::*;
#(
  parameter  int N_BTN        = 4,
  parameter  int DEBOUNCE_CYC = 16,
  localparam int ID_W         = id_width(N_BTN)
) (
  input  logic             clck_i,
  input  logic             rst_i,
  input  logic [N_BTN-1:0] btn_i,
  input  logic             ev_ack_i,
  output logic             ev_valid_o,
  output logic [ID_W-1:0]  ev_id_o,
  output logic [N_BTN-1:0] pend_o,
  output logic             overrun_o
`ifdef SWITCH_IRQ_EN
  , output logic           irq_o
`endif
);
  localparam logic [ID_W:0] NB = (ID_W + 1)'(N_BTN);
  logic [N_BTN-1:0] w_pulse, r_pend, w_rot, w_clr;
  logic [ID_W-1:0] r_id, r_ptr, w_off, w_gid, w_ptr_nx;
  logic [ID_W:0] w_sum;
  logic r_ovr, w_found, w_grant, w_lost;
  arb_state_t r_arb, w_arb_next;
  for (genvar b = 0; b < N_BTN; b++) begin : g_btn
    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_btn (
      .clck_i       (clck_i),
      .rst_i        (rst_i),
      .btn_i        (btn_i[b]),
      .release_pulse(w_pulse[b])
    );
  end
  // arbiter state register
  always_ff @(posedge clck_i or posedge rst_i) begin
    if (rst_i) r_arb <= ARB_IDLE;
    else r_arb <= w_arb_next;
  end
  // arbiter next state: grant when anything is pending, return to idle on ack
  always_comb begin
    w_arb_next = (r_arb == ARB_IDLE) ? (w_found ? ARB_PRESENT : ARB_IDLE) :
                 (ev_ack_i ? ARB_IDLE : ARB_PRESENT);
  end
  // arbiter outputs: rotate pend so the search starts at the pointer, then map back to a button index
  always_comb begin
    w_rot = N_BTN'({r_pend, r_pend} >> r_ptr);
    w_off = '0;
    for (int k = N_BTN - 1; k >= 0; k--) if (w_rot[k]) w_off = ID_W'(k);
    w_found  = |r_pend;
    w_sum    = {1'b0, r_ptr} + {1'b0, w_off};
    w_gid    = (w_sum >= NB) ? ID_W'(w_sum - NB) : ID_W'(w_sum);
    w_ptr_nx = (w_gid == ID_W'(N_BTN - 1)) ? '0 : w_gid + 1'b1;
    w_grant  = (r_arb == ARB_IDLE) && w_found;
    w_clr    = w_grant ? (N_BTN'(1) << w_gid) : '0;
    w_lost   = |(w_pulse & r_pend & ~w_clr);
  end
  // pending flags (a new pulse beats a same-cycle grant), sticky overrun, presented id and pointer
  always_ff @(posedge clck_i or posedge rst_i) begin
    if (rst_i) begin
      r_pend <= '0;
      r_ovr  <= 1'b0;
      r_id   <= '0;
      r_ptr  <= '0;
    end else begin
      r_pend <= (r_pend & ~w_clr) | w_pulse;
      if (w_lost) r_ovr <= 1'b1;
      if (w_grant) begin
        r_id  <= w_gid;
        r_ptr <= w_ptr_nx;
      end
    end
  end
  assign ev_valid_o = (r_arb == ARB_PRESENT);
  assign ev_id_o    = r_id;
  assign pend_o     = r_pend;
  assign overrun_o  = r_ovr;
`ifdef SWITCH_IRQ_EN
  logic r_irq;
  // irq is built from next-state values so it matches ev_valid_o | overrun_o on every cycle
  always_ff @(posedge clck_i or posedge rst_i) begin
    if (rst_i) r_irq <= 1'b0;
    else r_irq <= (w_arb_next == ARB_PRESENT) | r_ovr | w_lost;
  end
  assign irq_o = r_irq;
`endif
endmodule

// File: tb/tb_switch_event_ctrl.sv
// tb_switch_event_ctrl: table-driven and scoreboard checks of switch_event_ctrl with N_BTN=4, DEBOUNCE_CYC=4
module tb_switch_event_ctrl;
  localparam int N = 4, D = 4;
  logic clk = 1'b0, rst = 1'b1, ack = 1'b0;
  logic [3:0] btn = '0;
  logic valid, ovr;
  logic [1:0] id;
  logic [3:0] pend;
`ifdef SWITCH_IRQ_EN
  logic irq;
`endif
  int tests = 0, fails = 0;
  logic [1:0] q[$];
  logic [1:0] mptr = '0;
  typedef struct {
    logic [3:0] mask;
    int         hold;
    logic       ev;
  } vec_t;
  vec_t vecs[6];

  always #5 clk = ~clk;

  switch_event_ctrl #(.N_BTN(N), .DEBOUNCE_CYC(D)) dut (
    .clck_i    (clk),
    .rst_i     (rst),
    .btn_i     (btn),
    .ev_ack_i  (ack),
    .ev_valid_o(valid),
    .ev_id_o   (id),
    .pend_o    (pend),
    .overrun_o (ovr)
`ifdef SWITCH_IRQ_EN
    , .irq_o   (irq)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_irq(input string name);
`ifdef SWITCH_IRQ_EN
    chk({name, "_irq"}, 32'(irq), 32'(valid | ovr));
`endif
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [3:0] m, input int hold);
    btn = m;
    cyc(hold);
    btn = '0;
  endtask

  // reference round-robin order for buttons released together
  task automatic push_model(input logic [3:0] m);
    logic [1:0] p;
    p = mptr;
    for (int k = 0; k < N; k++) begin
      logic [1:0] i;
      i = p + 2'(k);
      if (m[i]) begin
        q.push_back(i);
        mptr = i + 2'd1;
      end
    end
  endtask

  task automatic get_event(input string name);
    int w;
    logic [1:0] e;
    w = 0;
    while (!valid && w < 40) begin
      @(negedge clk);
      w++;
    end
    e = q.pop_front();
    chk({name, "_valid"}, 32'(valid), 32'd1);
    if (valid) begin
      chk({name, "_id"}, 32'(id), 32'(e));
      chk_irq(name);
      ack = 1'b1;
      @(posedge clk);
      #1 chk({name, "_ackdrop"}, 32'(valid), 32'd0);
      @(negedge clk);
      ack = 1'b0;
    end
  endtask

  task automatic drain(input string name);
    while (q.size() != 0) get_event(name);
  endtask

  task automatic idle_chk(input string name);
    chk({name, "_valid"}, 32'(valid), 32'd0);
    chk({name, "_pend"}, 32'(pend), 32'd0);
    chk_irq(name);
  endtask

  initial begin
    int first;
    vecs[0] = '{4'b0001, 2, 1'b0};
    vecs[1] = '{4'b1000, 6, 1'b1};
    vecs[2] = '{4'b1010, 7, 1'b1};
    vecs[3] = '{4'b0001, 3, 1'b0};
    vecs[4] = '{4'b1111, 8, 1'b1};
    vecs[5] = '{4'b0110, 6, 1'b1};
    btn = 4'hf;
    cyc(3);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_id", 32'(id), 32'd0);
    chk("rst_pend", 32'(pend), 32'd0);
    chk("rst_ovr", 32'(ovr), 32'd0);
    chk_irq("rst");
    rst = 1'b0;
    btn = '0;
    cyc(3);
    btn = 4'b0100;
    cyc(10);
    btn = '0;
    push_model(4'b0100);
    first = 0;
    @(posedge clk);
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk);
      #1 if (valid && first == 0) first = k;
    end
    chk("lat_edges", 32'(first), 32'd9);
    @(negedge clk);
    get_event("lat");
    for (int v = 0; v < 6; v++) begin
      press(vecs[v].mask, vecs[v].hold);
      if (vecs[v].ev) push_model(vecs[v].mask);
      drain("vec");
      cyc(15);
      idle_chk("vec_idle");
    end
    press(4'b0001, 6);
    push_model(4'b0001);
    cyc(12);
    chk("ovr_v1", 32'(valid), 32'd1);
    press(4'b0001, 6);
    push_model(4'b0001);
    cyc(12);
    chk("ovr_pend", 32'(pend), 32'b0001);
    chk("ovr_pre", 32'(ovr), 32'd0);
    press(4'b0001, 6);
    cyc(12);
    chk("ovr_set", 32'(ovr), 32'd1);
    chk("ovr_pend2", 32'(pend), 32'b0001);
    chk_irq("ovr");
    drain("ovr_ev");
    cyc(15);
    idle_chk("ovr_idle");
    chk("ovr_sticky", 32'(ovr), 32'd1);
    press(4'b0001, 6);
    push_model(4'b0001);
    cyc(12);
    press(4'b0100, 6);
    cyc(12);
    chk("mid_valid", 32'(valid), 32'd1);
    chk("mid_pend", 32'(pend), 32'b0100);
    #2 rst = 1'b1;
    btn = 4'b0010;
    #1;
    chk("mid_rst_valid", 32'(valid), 32'd0);
    chk("mid_rst_pend", 32'(pend), 32'd0);
    chk("mid_rst_ovr", 32'(ovr), 32'd0);
    chk_irq("mid_rst");
    q.delete();
    mptr = '0;
    @(negedge clk);
    rst = 1'b0;
    ack = 1'b1;
    cyc(2);
    ack = 1'b0;
    cyc(15);
    idle_chk("held");
    btn = '0;
    push_model(4'b0010);
    drain("held_ev");
    cyc(15);
    idle_chk("end");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
